// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, display codes and the converter FSM encoding.
package bcd_pkg;

  localparam int BCD_WIDTH = 4;

  localparam logic [BCD_WIDTH-1:0] DIGIT_MINUS = 4'hA;
  localparam logic [BCD_WIDTH-1:0] DIGIT_BLANK = 4'hB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BLANK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Sign position code for a display: minus when negative, blank otherwise.
  function automatic logic [BCD_WIDTH-1:0] sign_digit(input logic neg);
    return neg ? DIGIT_MINUS : DIGIT_BLANK;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_converter_if.sv
// Request/result bundle between a value source and bin_to_bcd_seq_converter.
interface bin_to_bcd_seq_converter_if #(
  parameter int SEQ_LEN = 20,
  parameter int DIGITS  = 6
) ();
  import bcd_pkg::*;

  // start is a request sampled only while the converter is IDLE (no queuing);
  // done is a one-cycle completion pulse and bcd_out/neg_out change only with it.
  logic                          start;
  logic [SEQ_LEN-1:0]            bin_in;
  logic                          busy;
  logic                          done;
  logic [DIGITS*BCD_WIDTH-1:0]   bcd_out;
  logic                          neg_out;
  state_e                        state_dbg;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, neg_out, state_dbg
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, neg_out, state_dbg
  );

endinterface

// File: rtl/bin_to_bcd_seq_converter_add3_column.sv
// One double-dabble correction column: a digit of 5 or more gets +3 before the shift.
module bcd_add3_column
  import bcd_pkg::*;
(
  input  logic [BCD_WIDTH-1:0] digit_i,
  output logic [BCD_WIDTH-1:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/bin_to_bcd_seq_converter.sv
// Sequential signed binary-to-BCD converter, one double-dabble shift per clock.
// Optional leading-zero blanking pass enabled by defining LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int SEQ_LEN = 20,
  parameter int DIGITS  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  bin_to_bcd_seq_converter_if.slave  bus
);

  localparam int ACC_W = DIGITS * BCD_WIDTH;
  localparam int CNT_W = $clog2(SEQ_LEN + 1);

  localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;
  localparam longint unsigned BIN_RANGE = 64'd1 << (SEQ_LEN - 1);

  generate
    if (DEC_RANGE <= BIN_RANGE) begin : g_range_check
      $error("DIGITS too small to hold the magnitude of a SEQ_LEN-bit signed value");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [SEQ_LEN-1:0] mag_q,   mag_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               sign_q,  sign_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [ACC_W-1:0]   bcd_q,   bcd_d;
  logic               neg_q,   neg_d;

  logic [ACC_W-1:0]   acc_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_col
    bcd_add3_column u_col (
      .digit_i (acc_q[g*BCD_WIDTH +: BCD_WIDTH]),
      .digit_o (acc_adj[g*BCD_WIDTH +: BCD_WIDTH])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [ACC_W-1:0] acc_blank;
  logic             leading;

  // Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    acc_blank = acc_q;
    leading   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && (acc_q[i*BCD_WIDTH +: BCD_WIDTH] == '0)) begin
        acc_blank[i*BCD_WIDTH +: BCD_WIDTH] = DIGIT_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    neg_d   = neg_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          // The most negative input negates to itself, which is its correct unsigned magnitude.
          mag_d   = bus.bin_in[SEQ_LEN-1] ? (~bus.bin_in + SEQ_LEN'(1)) : bus.bin_in;
          sign_d  = bus.bin_in[SEQ_LEN-1];
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        {acc_d, mag_d} = {acc_adj, mag_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SEQ_LEN - 1)) begin
`ifdef LEADING_ZERO_BLANK_EN
          state_d = BLANK;
`else
          state_d = DONE;
`endif
        end
      end
      BLANK: begin
`ifdef LEADING_ZERO_BLANK_EN
        acc_d   = acc_blank;
        state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        done_d  = 1'b1;
        bcd_d   = acc_q;
        neg_d   = sign_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT) || (state_d == BLANK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.neg_out   = neg_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq_converter.sv
// Scoreboard bench for bin_to_bcd_seq_converter: randomized and directed conversions
// checked against an arithmetic decimal model, including latency, busy and output hold.
module tb_bin_to_bcd_seq_converter;
  import bcd_pkg::*;

  localparam int SEQ_LEN = 20;
  localparam int DIGITS  = 6;
  localparam int ACC_W   = DIGITS * BCD_WIDTH;
`ifdef LEADING_ZERO_BLANK_EN
  localparam int LAT     = SEQ_LEN + 2;
  localparam int BUSY_N  = SEQ_LEN + 1;
`else
  localparam int LAT     = SEQ_LEN + 1;
  localparam int BUSY_N  = SEQ_LEN;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq_converter_if #(.SEQ_LEN(SEQ_LEN), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq_converter #(.SEQ_LEN(SEQ_LEN), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [ACC_W:0] exp_q[$];
  int unsigned    lat_q[$];
  logic [ACC_W:0] held_exp    = '0;
  int unsigned    busy_from   = 0;
  int unsigned    busy_to     = 0;
  int unsigned    next_accept = 0;
  bit             mon_en      = 1'b0;
  int             n_checks    = 0;
  int             n_errors    = 0;

  // Decimal reference: sign plus magnitude digits by repeated division.
  function automatic logic [ACC_W:0] ref_model(input logic [SEQ_LEN-1:0] v);
    longint           s;
    longint           m;
    logic [ACC_W-1:0] d;
    bit               lead;
    s = longint'($signed(v));
    m = (s < 0) ? -s : s;
    d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d[i*BCD_WIDTH +: BCD_WIDTH] = 4'(m % 10);
      m = m / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && d[i*BCD_WIDTH +: BCD_WIDTH] == 4'd0) d[i*BCD_WIDTH +: BCD_WIDTH] = DIGIT_BLANK;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return {(s < 0), d};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock of stimulus, entered and left at a falling edge.
  task automatic step(input logic s, input logic r, input logic [SEQ_LEN-1:0] v);
    int unsigned e;
    bus.start  = s;
    bus.bin_in = v;
    rst        = r;
    e          = cyc + 1;
    if (!r && s && e >= next_accept) begin
      exp_q.push_back(ref_model(v));
      lat_q.push_back(e + LAT);
      busy_from   = e;
      busy_to     = e + BUSY_N;
      next_accept = e + LAT + 1;
    end
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      lat_q.delete();
      held_exp    = '0;
      busy_to     = 0;
      next_accept = e + 1;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 4 * LAT;
    while (cyc + 1 < next_accept && budget > 0) begin
      step(1'b0, 1'b0, SEQ_LEN'($urandom));
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_wait: converter still expected busy after %0d cycles", 4 * LAT);
    end
  endtask

  task automatic convert(input logic [SEQ_LEN-1:0] v);
    wait_idle();
    step(1'b1, 1'b0, v);
    wait_idle();
  endtask

  task automatic check_idle_state(input string tag);
    n_checks++;
    if (bus.state_dbg !== IDLE) begin
      n_errors++;
      $display("FAIL %s: state_dbg=%0d required IDLE", tag, bus.state_dbg);
    end
  endtask

  function automatic logic [SEQ_LEN-1:0] rand_value();
    case ($urandom_range(0, 5))
      0:       return {1'b1, {(SEQ_LEN-1){1'b0}}};
      1:       return {1'b0, {(SEQ_LEN-1){1'b1}}};
      2:       return '0;
      3:       return SEQ_LEN'($urandom_range(0, 99));
      default: return SEQ_LEN'($urandom);
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic           exp_busy;
      logic [ACC_W:0] exp_v;
      int unsigned    exp_lat;
      exp_busy = (cyc >= busy_from) && (cyc < busy_to);
      n_checks++;
      if (bus.busy !== exp_busy) begin
        n_errors++;
        $display("FAIL busy: cycle %0d busy=%b required %b", cyc, bus.busy, exp_busy);
      end
      if (bus.done === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_done: cycle %0d done=1 with no conversion outstanding", cyc);
        end else begin
          exp_v   = exp_q.pop_front();
          exp_lat = lat_q.pop_front();
          if (exp_lat != cyc) begin
            n_errors++;
            $display("FAIL done_latency: done at cycle %0d required cycle %0d", cyc, exp_lat);
          end
          n_checks++;
          if ({bus.neg_out, bus.bcd_out} !== exp_v) begin
            n_errors++;
            $display("FAIL result: neg=%b bcd=%h required neg=%b bcd=%h",
                     bus.neg_out, bus.bcd_out, exp_v[ACC_W], exp_v[ACC_W-1:0]);
          end
          held_exp = exp_v;
        end
      end else begin
        n_checks++;
        if ({bus.neg_out, bus.bcd_out} !== held_exp) begin
          n_errors++;
          $display("FAIL hold: cycle %0d neg=%b bcd=%h required neg=%b bcd=%h", cyc,
                   bus.neg_out, bus.bcd_out, held_exp[ACC_W], held_exp[ACC_W-1:0]);
        end
        if (lat_q.size() > 0 && lat_q[0] == cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL missed_done: done=%b at cycle %0d required 1", bus.done, cyc);
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
    @(negedge clk);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    mon_en = 1'b1;
    check_idle_state("reset_state");
    step(1'b0, 1'b0, '0);

    // directed values
    convert(SEQ_LEN'(12345));
    convert(20'h80000);
    convert('0);
    convert(20'h7FFFF);
    convert(SEQ_LEN'(-1));
    convert(SEQ_LEN'(42));

    // start pulses during SHIFT and during DONE are ignored
    step(1'b1, 1'b0, SEQ_LEN'(111));
    repeat (5) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, SEQ_LEN'(222));
    repeat (5) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, SEQ_LEN'(-333));
    while (cyc + 2 < next_accept) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, SEQ_LEN'(444));
    wait_idle();

    // reset in the middle of a conversion aborts it
    step(1'b1, 1'b0, SEQ_LEN'(98765));
    repeat (10) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    check_idle_state("abort_reset");
    convert(SEQ_LEN'(-4321));

    // reset and start together: reset wins
    step(1'b1, 1'b1, SEQ_LEN'(555));
    check_idle_state("rst_with_start");
    convert(SEQ_LEN'(555));

    // start held high across three conversions with a changing value
    for (int n = 0; n < 3 * (LAT + 1); n++) step(1'b1, 1'b0, rand_value());
    wait_idle();

    // random traffic with stray starts and occasional resets
    for (int n = 0; n < 40; n++) begin
      step(1'b1, 1'b0, rand_value());
      for (int g = 0; g < $urandom_range(0, LAT + 3); g++) begin
        if ($urandom_range(0, 29) == 0) step(1'b0, 1'b1, rand_value());
        else step(($urandom_range(0, 5) == 0), 1'b0, rand_value());
      end
    end
    wait_idle();
    repeat (2) step(1'b0, 1'b0, '0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
